// File: rtl/ibex_ex_issue_pkg.sv
// Shared types for the EX issue stage: ALU / mult-div operator encodings
// and the issue controller state encoding.
package ibex_ex_issue_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_XOR  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_AND  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    EXI_IDLE  = 2'd0,
    EXI_EXEC  = 2'd1,
    EXI_DRAIN = 2'd2
  } ex_issue_state_e;

endpackage

// File: rtl/ibex_ex_issue.sv
// ibex_ex_issue: issue/hold/writeback controller in front of ibex_ex_block.
// Accepts one decoded instruction per valid/ready handshake, holds operator,
// operands and unit enables stable until ex_ready_i, then registers the EX
// result and pulses a one-cycle register-file write.
// Ports: id_* decoded instruction in, *_o held copies to EX, ex_ready_i /
// regfile_wdata_ex_i from EX, rf_* writeback, flush_i kill, busy_o held flag.
// Parameter RV32M: 0 forces mult/div enables low.
// Optional macro IBEX_EX_ISSUE_STALL_CNT_EN adds stall_cnt_o (saturating
// count of cycles held while EX is not ready).
module ibex_ex_issue
  import ibex_ex_issue_pkg::*;
#(
  parameter bit RV32M = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  alu_op_e     id_alu_operator_i,
  input  md_op_e      id_multdiv_operator_i,
  input  logic        id_mult_en_i,
  input  logic        id_div_en_i,
  input  logic        id_lsu_en_i,
  input  logic [31:0] id_operand_a_i,
  input  logic [31:0] id_operand_b_i,
  input  logic [31:0] id_md_operand_a_i,
  input  logic [31:0] id_md_operand_b_i,
  input  logic [1:0]  id_md_signed_mode_i,
  input  logic        id_rf_we_i,
  input  logic [4:0]  id_rf_waddr_i,
  input  logic        flush_i,
  output alu_op_e     alu_operator_o,
  output md_op_e      multdiv_operator_o,
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        lsu_en_o,
  output logic [31:0] alu_operand_a_o,
  output logic [31:0] alu_operand_b_o,
  output logic [31:0] multdiv_operand_a_o,
  output logic [31:0] multdiv_operand_b_o,
  output logic [1:0]  multdiv_signed_mode_o,
  input  logic        ex_ready_i,
  input  logic [31:0] regfile_wdata_ex_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
`ifdef IBEX_EX_ISSUE_STALL_CNT_EN
  output logic [31:0] stall_cnt_o,
`endif
  output logic        busy_o
);

  ex_issue_state_e state_q, state_d;

  alu_op_e     alu_op_q;
  md_op_e      md_op_q;
  logic        mult_en_q, div_en_q, lsu_en_q;
  logic [31:0] opa_q, opb_q, md_opa_q, md_opb_q;
  logic [1:0]  md_signed_q;
  logic        held_we_q;
  logic [4:0]  held_waddr_q;

  logic        wb_we_q;
  logic [4:0]  wb_waddr_q;
  logic [31:0] wb_wdata_q;

  logic accept, complete, clear_en;

  always_comb begin
    state_d    = state_q;
    id_ready_o = 1'b0;
    complete   = 1'b0;
    clear_en   = 1'b0;
    unique case (state_q)
      EXI_IDLE: begin
        id_ready_o = !flush_i;
        if (id_valid_i && !flush_i) state_d = EXI_EXEC;
      end
      EXI_EXEC: begin
        if (flush_i) begin
          // A started bus access cannot be aborted: keep lsu_en until done.
          if (lsu_en_q && !ex_ready_i) begin
            state_d = EXI_DRAIN;
          end else begin
            state_d  = EXI_IDLE;
            clear_en = 1'b1;
          end
        end else if (ex_ready_i) begin
          complete   = 1'b1;
          id_ready_o = 1'b1;
          if (!id_valid_i) begin
            state_d  = EXI_IDLE;
            clear_en = 1'b1;
          end
        end
      end
      EXI_DRAIN: begin
        if (ex_ready_i) begin
          state_d  = EXI_IDLE;
          clear_en = 1'b1;
        end
      end
      default: state_d = EXI_IDLE;
    endcase
  end

  assign accept = id_valid_i && id_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= EXI_IDLE;
      alu_op_q     <= ALU_ADD;
      md_op_q      <= MD_OP_MULL;
      mult_en_q    <= 1'b0;
      div_en_q     <= 1'b0;
      lsu_en_q     <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      md_opa_q     <= '0;
      md_opb_q     <= '0;
      md_signed_q  <= '0;
      held_we_q    <= 1'b0;
      held_waddr_q <= '0;
      wb_we_q      <= 1'b0;
      wb_waddr_q   <= '0;
      wb_wdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_op_q     <= id_alu_operator_i;
        md_op_q      <= id_multdiv_operator_i;
        mult_en_q    <= RV32M ? id_mult_en_i : 1'b0;
        div_en_q     <= RV32M ? id_div_en_i : 1'b0;
        lsu_en_q     <= id_lsu_en_i;
        opa_q        <= id_operand_a_i;
        opb_q        <= id_operand_b_i;
        md_opa_q     <= id_md_operand_a_i;
        md_opb_q     <= id_md_operand_b_i;
        md_signed_q  <= id_md_signed_mode_i;
        held_we_q    <= id_rf_we_i;
        held_waddr_q <= id_rf_waddr_i;
      end else if (clear_en) begin
        mult_en_q <= 1'b0;
        div_en_q  <= 1'b0;
        lsu_en_q  <= 1'b0;
      end
      wb_we_q <= complete && held_we_q && (held_waddr_q != 5'd0);
      if (complete) begin
        wb_waddr_q <= held_waddr_q;
        wb_wdata_q <= regfile_wdata_ex_i;
      end
    end
  end

`ifdef IBEX_EX_ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if ((state_q != EXI_IDLE) && !ex_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
  assign stall_cnt_o = stall_cnt_q;
`endif

  assign alu_operator_o        = alu_op_q;
  assign multdiv_operator_o    = md_op_q;
  assign mult_en_o             = mult_en_q;
  assign div_en_o              = div_en_q;
  assign lsu_en_o              = lsu_en_q;
  assign alu_operand_a_o       = opa_q;
  assign alu_operand_b_o       = opb_q;
  assign multdiv_operand_a_o   = md_opa_q;
  assign multdiv_operand_b_o   = md_opb_q;
  assign multdiv_signed_mode_o = md_signed_q;
  assign rf_we_o               = wb_we_q;
  assign rf_waddr_o            = wb_waddr_q;
  assign rf_wdata_o            = wb_wdata_q;
  assign busy_o                = (state_q != EXI_IDLE);

endmodule
